// File: rtl/cm_scan_pkg.sv
// Shared constants and types for the 16:1 mux scan controller.
package cm_scan_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Returns w with bit k replaced by b.
    function automatic logic [NUM_CH-1:0] put_bit(input logic [NUM_CH-1:0] w,
                                                   input logic [SEL_W-1:0]  k,
                                                   input logic              b);
        logic [NUM_CH-1:0] r;
        r    = w;
        r[k] = b;
        return r;
    endfunction

endpackage

// File: rtl/cm_scan_settle_cnt.sv
// Loadable settle down-counter; zero flag marks the cycle the mux output may be sampled.
module cm_scan_settle_cnt
    import cm_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(SETTLE);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cm_mux_scan_ctrl.sv
// Scan controller walking a 16:1 inverting mux and assembling the samples into a word.
// Optional parity output word_par is built when CM_SCAN_PARITY_EN is defined.
module cm_mux_scan_ctrl
    import cm_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              abort,
    output logic [SEL_W-1:0]  mux_sel,
    output logic              mux_en_n,
    input  logic              mux_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [NUM_CH-1:0] word_data,
    output logic              busy
`ifdef CM_SCAN_PARITY_EN
    ,
    output logic              word_par
`endif
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

    scan_state_t       state;
    logic              start_hs;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_zero;
    logic [NUM_CH-1:0] word_next;

    assign start_hs = start_valid & start_ready;

    always_comb begin
        word_next = put_bit(word_data, mux_sel, ~mux_out);
        cnt_en    = (state == SCAN) && !abort;
        // Reload on scan entry and on every channel advance except the last.
        cnt_load  = ((state == IDLE) && start_hs) ||
                    (cnt_en && cnt_zero && (mux_sel != LAST_SEL));
    end

    cm_scan_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .en    (cnt_en),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mux_sel     <= '0;
            mux_en_n    <= 1'b1;
            word_valid  <= 1'b0;
            word_data   <= '0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
`ifdef CM_SCAN_PARITY_EN
            word_par    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A concurrent abort is meaningless here, so start always wins.
                    if (start_hs) begin
                        state       <= SCAN;
                        mux_sel     <= '0;
                        mux_en_n    <= 1'b0;
                        busy        <= 1'b1;
                        start_ready <= 1'b0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state       <= IDLE;
                        mux_en_n    <= 1'b1;
                        mux_sel     <= '0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end else if (cnt_zero) begin
                        word_data <= word_next;
`ifdef CM_SCAN_PARITY_EN
                        word_par  <= ^word_next;
`endif
                        if (mux_sel != LAST_SEL) begin
                            mux_sel <= mux_sel + SEL_W'(1);
                        end else begin
                            mux_en_n   <= 1'b1;
                            mux_sel    <= '0;
                            word_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (word_ready) begin
                        word_valid  <= 1'b0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
